// File: rtl/lif_tdm_if.sv
// lif_tdm_if: host/router-side bundle of the LIF TDM scheduler
//   tick, wr_en/wr_idx/wr_i, rd_idx, ev_ready : driven by master
//   rd_v, busy, sweep_done, ev_valid, ev_idx, tick_ovr : driven by slave
interface lif_tdm_if #(parameter int IDX_W = 3);
    logic              tick;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic signed [7:0] wr_i;
    logic [IDX_W-1:0]  rd_idx;
    logic signed [7:0] rd_v;
    logic              busy;
    logic              sweep_done;
    logic              ev_valid;
    logic [IDX_W-1:0]  ev_idx;
    logic              ev_ready;
    logic              tick_ovr;
    modport master (
        output tick, wr_en, wr_idx, wr_i, rd_idx, ev_ready,
        input  rd_v, busy, sweep_done, ev_valid, ev_idx, tick_ovr
    );
    modport slave (
        input  tick, wr_en, wr_idx, wr_i, rd_idx, ev_ready,
        output rd_v, busy, sweep_done, ev_valid, ev_idx, tick_ovr
    );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: one Q4.4 leaky integrate-and-fire datapath shared by N_NEURONS virtual neurons
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : lif_tdm_if.slave (tick/current write/debug read/spike event handshake/status)
module lif_tdm_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3,
    parameter int THRESH    = 64,
    parameter int LSH       = 3,
    parameter int V_MAX     = 127,
    parameter int NEG_DRIVE = 16
) (
    input logic     clk,
    input logic     rst_n,
    lif_tdm_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      cnt;
    logic signed [7:0]     v     [N_NEURONS];
    logic signed [7:0]     i_mem [N_NEURONS];
    logic [N_NEURONS-1:0]  refr;
    logic signed [7:0]     cur_v, cur_i, leak, norm, refv;
    logic signed [9:0]     v10, i10, l10, norm_w, refv_w;
    logic                  cur_r, upd, spike;

    function automatic logic signed [7:0] sat(input logic signed [9:0] x);
        return x > 10'sd127 ? 8'sh7f : (x < -10'sd128 ? 8'sh80 : x[7:0]);
    endfunction

    // Sums are formed 10 bits wide so the threshold tests see the unsaturated value;
    // with THRESH <= 127 that gives the same decision as testing the saturated one.
    always_comb begin
        cur_v  = v[cnt];
        cur_i  = i_mem[cnt];
        cur_r  = refr[cnt];
        leak   = cur_v >>> LSH;
        v10    = cur_v;
        i10    = cur_i;
        l10    = leak;
        norm_w = v10 + i10 - l10;
        refv_w = v10 - l10 - 10'(NEG_DRIVE);
        norm   = sat(norm_w);
        refv   = sat(refv_w);
        spike  = !cur_r && norm_w >= 10'(THRESH);
        // an unaccepted event freezes the sweep in place
        upd    = state == SWEEP && !(bus.ev_valid && !bus.ev_ready);
    end

    assign bus.busy = state == SWEEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            refr           <= '0;
            bus.rd_v       <= '0;
            bus.sweep_done <= 1'b0;
            bus.ev_valid   <= 1'b0;
            bus.ev_idx     <= '0;
            bus.tick_ovr   <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v[k]     <= '0;
                i_mem[k] <= '0;
            end
        end else begin
            bus.rd_v       <= v[bus.rd_idx];
            bus.sweep_done <= 1'b0;
            if (bus.tick && state == SWEEP) bus.tick_ovr <= 1'b1;
            if (bus.tick && state == IDLE) begin
                state <= SWEEP;
                cnt   <= '0;
            end
            if (upd) begin
                i_mem[cnt] <= '0;
                if (cur_r) begin
                    v[cnt] <= refv;
                    if (refv_w <= 10'(-THRESH)) refr[cnt] <= 1'b0;
                end else if (spike) begin
                    v[cnt]    <= 8'(V_MAX);
                    refr[cnt] <= 1'b1;
                end else begin
                    v[cnt] <= norm;
                end
                if (cnt == IDX_W'(N_NEURONS - 1)) begin
                    state          <= IDLE;
                    bus.sweep_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // a fresh spike replaces an event accepted in the same cycle
            if (upd && spike) begin
                bus.ev_valid <= 1'b1;
                bus.ev_idx   <= cnt;
            end else if (bus.ev_valid && bus.ev_ready) begin
                bus.ev_valid <= 1'b0;
            end
            // placed after the clear so a same-cycle write survives into the next sweep
            if (bus.wr_en && 32'(bus.wr_idx) < N_NEURONS) i_mem[bus.wr_idx] <= bus.wr_i;
        end
    end
endmodule
